// File: rtl/i2s_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------+
// | Package     : i2s_pkg                                              |
// | Description : Shared constants and types for the I2S slave         |
// |               receiver: default word/counter widths, channel       |
// |               codes carried on LRCLK, and receiver FSM encoding.   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package i2s_pkg;

  // Default PCM word width captured per channel (MSB first).
  localparam int DATA_W_DEFAULT = 16;

  // Default bit-counter width; the counter saturates at 2**CNT_W-1.
  localparam int CNT_W_DEFAULT = 6;

  // LRCLK level per channel.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Receiver state: HUNT waits for the first word-select change so that
  // the partial slot seen right after reset is never stored.
  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_e;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_sync_edge.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------+
// | Module      : i2s_sync_edge                                        |
// | Description : Two-flop synchronizer for one asynchronous pin, with |
// |               an optional third flop producing a one-cycle rising  |
// |               edge strobe aligned with the synchronized level.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
// | Ports                                                              |
// |   clk_in   in   1  sampling clock                                  |
// |   ar       in   1  asynchronous reset, active-high                  |
// |   async_i  in   1  asynchronous pin                                 |
// |   sync_o   out  1  synchronized level (second flop)                 |
// |   rise_o   out  1  rising-edge strobe (0 when EDGE_EN = 0)          |
// +--------------------------------------------------------------------+
module i2s_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk_in,
  input  logic ar,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_in or posedge ar) begin
    if (ar) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
    end
  end

  assign sync_o = s2_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic s3_q;

      always_ff @(posedge clk_in or posedge ar) begin
        if (ar) begin
          s3_q <= 1'b0;
        end else begin
          s3_q <= s2_q;
        end
      end

      // High for exactly the cycle in which s2 has just gone high, so the
      // strobe lines up with the s2 stage of sibling synchronizers.
      assign rise_o = s2_q & ~s3_q;
    end else begin : g_sync_only
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule : i2s_sync_edge
`default_nettype wire

// File: rtl/i2s_rx_slave.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------+
// | Module      : i2s_rx_slave                                         |
// | Description : I2S slave receiver. Oversamples externally driven    |
// |               BCLK/LRCLK/SDATA with clk_in (clk_in >= 4x BCLK),    |
// |               recovers left/right PCM words and presents each      |
// |               stereo pair on a valid/ready output.                 |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
// | Ports                                                              |
// |   clk_in       in   1       system clock                           |
// |   ar           in   1       asynchronous reset, active-high        |
// |   bclk         in   1       I2S bit clock (async)                  |
// |   lrclk        in   1       I2S word select (async), 0=left        |
// |   sdata        in   1       I2S serial data (async)                |
// |   left_data    out  DATA_W  left sample of current pair            |
// |   right_data   out  DATA_W  right sample of current pair           |
// |   out_valid    out  1       pair available, held until accepted    |
// |   out_ready    in   1       consumer accepts when valid & ready    |
// |   overrun      out  1       sticky: unaccepted pair overwritten    |
// |   clr_overrun  in   1       synchronous clear of overrun           |
// |   frame_err    out  1       pulse: slot closed with < DATA_W bits  |
// +--------------------------------------------------------------------+
module i2s_rx_slave
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk_in,
  input  logic              ar,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic              frame_err
);

  // ------------------------------------------------------------------
  // Input synchronization
  // ------------------------------------------------------------------
  logic bclk_rise;
  logic bclk_s_unused;
  logic lr_s;
  logic lr_rise_unused;
  logic sd_s;
  logic sd_rise_unused;

  i2s_sync_edge #(.EDGE_EN(1'b1)) u_sync_bclk (
    .clk_in  (clk_in),
    .ar      (ar),
    .async_i (bclk),
    .sync_o  (bclk_s_unused),
    .rise_o  (bclk_rise)
  );

  i2s_sync_edge #(.EDGE_EN(1'b0)) u_sync_lrclk (
    .clk_in  (clk_in),
    .ar      (ar),
    .async_i (lrclk),
    .sync_o  (lr_s),
    .rise_o  (lr_rise_unused)
  );

  i2s_sync_edge #(.EDGE_EN(1'b0)) u_sync_sdata (
    .clk_in  (clk_in),
    .ar      (ar),
    .async_i (sdata),
    .sync_o  (sd_s),
    .rise_o  (sd_rise_unused)
  );

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  rx_state_e         state_q;
  rx_state_e         state_d;
  logic              lr_prev_q;    // LRCLK at the previous bclk_rise: owner of the current bit
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] lhold_q;      // completed left word awaiting its right partner
  logic              left_ok_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] right_q;
  logic              valid_q;
  logic              overrun_q;
  logic              ferr_q;

  // ------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------
  logic              run;
  logic              capture;
  logic              slot_close;
  logic              short_slot;
  logic              load_pair;
  logic [CNT_W:0]    cnt_ext;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] shift_d;      // shift register with the current bit inserted

  assign cnt_ext    = {1'b0, cnt_q};
  assign slot_close = bclk_rise & (lr_s != lr_prev_q);
  assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  // cnt_ext + 1 is the number of bits in the slot, including the closing one.
  assign short_slot = (cnt_ext + 1'b1) < (CNT_W + 1)'(DATA_W);

  // Bit number cnt lands at position DATA_W-1-cnt; once the word is full
  // further bits match no position and are dropped (truncation).
  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt_ext == (CNT_W + 1)'(DATA_W - 1 - i)) begin
        shift_d[i] = sd_s;
      end
    end
  end

  // ------------------------------------------------------------------
  // Receiver FSM: state register / next state / outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge ar) begin
    if (ar) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_HUNT) && slot_close) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    run     = (state_q == ST_RUN);
    capture = run & bclk_rise;
  end

  // A right slot only forms a pair if a complete left slot preceded it.
  assign load_pair = capture & slot_close & (lr_prev_q == CH_RIGHT) & left_ok_q;

  // ------------------------------------------------------------------
  // Bit capture and slot close
  // ------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge ar) begin
    if (ar) begin
      lr_prev_q <= CH_LEFT;
      cnt_q     <= '0;
      shift_q   <= '0;
      lhold_q   <= '0;
      left_ok_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (bclk_rise) begin
        lr_prev_q <= lr_s;
      end
      if (capture) begin
        if (slot_close) begin
          // Clearing the shift register leaves short slots left-justified
          // and zero-padded.
          cnt_q   <= '0;
          shift_q <= '0;
          ferr_q  <= short_slot;
          if (lr_prev_q == CH_LEFT) begin
            lhold_q   <= shift_d;
            left_ok_q <= 1'b1;
          end else begin
            left_ok_q <= 1'b0;
          end
        end else begin
          cnt_q   <= cnt_inc;
          shift_q <= shift_d;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Output register and valid/ready handshake
  // ------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge ar) begin
    if (ar) begin
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_pair) begin
        left_q  <= lhold_q;
        right_q <= shift_d;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      // Setting has priority over a simultaneous clear.
      if (load_pair && valid_q && !out_ready) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign left_data  = left_q;
  assign right_data = right_q;
  assign out_valid  = valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = ferr_q;

endmodule : i2s_rx_slave
`default_nettype wire

// File: tb/tb_i2s_rx_slave.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------+
// | Module      : tb_i2s_rx_slave                                      |
// | Description : Self-checking bench for i2s_rx_slave. Drives I2S     |
// |               frames (MSB first, one-bit LRCLK lead) and compares  |
// |               received pairs with a word-level reference model.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_i2s_rx_slave;

  localparam int DW      = 16;
  localparam int NPAIRS  = 300;

  logic          clk_in = 1'b0;
  logic          ar;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic          clr_overrun;
  logic          frame_err;

  always #10 clk_in = ~clk_in;

  i2s_rx_slave dut (
    .clk_in      (clk_in),
    .ar          (ar),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .left_data   (left_data),
    .right_data  (right_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .frame_err   (frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: an n-bit MSB-first word as seen in a DW-bit register,
  // left-justified, zero-padded when short and truncated when long.
  function automatic logic [DW-1:0] model_word(input int n, input logic [31:0] v);
    logic [63:0] w;
    w = {32'h0, v} << (64 - n);
    return w[63 -: DW];
  endfunction

  // ---------------- I2S driver ----------------
  time half_ns = 80;
  bit  jitter  = 1'b0;

  task automatic bit_period(input logic lr, input logic d);
    time h1;
    time h2;
    h1 = half_ns;
    h2 = half_ns;
    if (jitter) begin
      h1 = half_ns - 3 + $urandom_range(0, 6);
      h2 = half_ns - 3 + $urandom_range(0, 6);
    end
    lrclk = lr;
    sdata = d;
    bclk  = 1'b0;
    #h1;
    bclk  = 1'b1;
    #h2;
  endtask

  // LRCLK switches to the next channel on the last bit of a slot.
  task automatic send_slot(input logic ch, input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) begin
      bit_period((i == n - 1) ? ~ch : ch, v[n-1-i]);
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] lv, input logic [31:0] rv);
    send_slot(1'b0, n, lv);
    send_slot(1'b1, n, rv);
  endtask

  task automatic idle(input int k);
    bclk = 1'b0;
    repeat (k) @(negedge clk_in);
  endtask

  // ---------------- Monitor ----------------
  int            npairs = 0;
  int            nferr  = 0;
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_r = '0;
  bit            use_q  = 1'b0;
  logic [2*DW-1:0] exp_q[$];

  always @(negedge clk_in) begin
    if (frame_err === 1'b1) nferr++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      npairs++;
      last_l = left_data;
      last_r = right_data;
      if (use_q) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rand_pair: got %h/%h, expected no pair", left_data, right_data);
        end else begin
          chk("rand_pair", {16'h0, left_data, right_data} & 32'hFFFF_FFFF, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  bit rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- Vector table ----------------
  typedef struct {
    int            n;
    logic [31:0]   lv;
    logic [31:0]   rv;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    int            eferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int p0;
    int f0;
    logic [31:0] lv;
    logic [31:0] rv;
    int n;

    vecs[0] = '{32, 32'hA5C3_1234, 32'h3C5A_8765, 16'hA5C3, 16'h3C5A, 0};
    vecs[1] = '{32, 32'hA5C3_FFFF, 32'h3C5A_0001, 16'hA5C3, 16'h3C5A, 0};
    vecs[2] = '{12, 32'h0000_0ABC, 32'h0000_0ABC, 16'hABC0, 16'hABC0, 2};
    vecs[3] = '{24, 32'h0012_3456, 32'h0065_4321, 16'h1234, 16'h6543, 0};
    vecs[4] = '{16, 32'h0000_FFFF, 32'h0000_0001, 16'hFFFF, 16'h0001, 0};
    vecs[5] = '{15, 32'h0000_7FFF, 32'h0000_2AAA, 16'hFFFE, 16'h5554, 2};
    vecs[6] = '{17, 32'h0001_FFFF, 32'h0000_0001, 16'hFFFF, 16'h0000, 0};

    ar = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    out_ready = 1'b1; clr_overrun = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_left", left_data, 0);
    chk("reset_right", right_data, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_err", frame_err, 0);
    ar = 1'b0;
    idle(4);

    // First frame after reset is only used to find the frame boundary.
    send_frame(32, 32'hA5C3_1234, 32'h3C5A_8765);
    idle(12);
    chk("first_frame_dropped", npairs, 0);

    for (int i = 0; i < 7; i++) begin
      p0 = npairs;
      f0 = nferr;
      send_frame(vecs[i].n, vecs[i].lv, vecs[i].rv);
      idle(12);
      chk($sformatf("vec%0d_pairs", i), npairs - p0, 1);
      chk($sformatf("vec%0d_left", i), last_l, vecs[i].el);
      chk($sformatf("vec%0d_right", i), last_r, vecs[i].er);
      chk($sformatf("vec%0d_frame_err", i), nferr - f0, vecs[i].eferr);
      chk($sformatf("vec%0d_valid_low", i), out_valid, 0);
    end

    // Consumer stalled for two frames: second pair overwrites the first.
    @(posedge clk_in); #1;
    out_ready = 1'b0;
    idle(2);
    send_frame(16, 32'h1111, 32'h2222);
    idle(12);
    chk("stall1_valid", out_valid, 1);
    chk("stall1_left", left_data, 16'h1111);
    chk("stall1_overrun", overrun, 0);
    send_frame(16, 32'h3333, 32'h4444);
    idle(12);
    chk("stall2_left", left_data, 16'h3333);
    chk("stall2_right", right_data, 16'h4444);
    chk("stall2_valid", out_valid, 1);
    chk("stall2_overrun", overrun, 1);
    @(posedge clk_in); #1;
    clr_overrun = 1'b1;
    @(posedge clk_in); #1;
    clr_overrun = 1'b0;
    @(negedge clk_in);
    chk("clr_overrun", overrun, 0);
    chk("clr_keeps_valid", out_valid, 1);
    @(posedge clk_in); #1;
    out_ready = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("accept_drops_valid", out_valid, 0);

    // Reset in the middle of a right slot, then re-hunt.
    idle(2);
    send_slot(1'b0, 16, 32'h5555);
    for (int i = 0; i < 8; i++) bit_period(1'b1, 1'b1);
    ar = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("midreset_valid", out_valid, 0);
    chk("midreset_left", left_data, 0);
    chk("midreset_right", right_data, 0);
    chk("midreset_overrun", overrun, 0);
    chk("midreset_frame_err", frame_err, 0);
    @(posedge clk_in); #1;
    ar = 1'b0;
    p0 = npairs;
    for (int i = 8; i < 16; i++) bit_period((i == 15) ? 1'b0 : 1'b1, 1'b0);
    idle(12);
    chk("rehunt_partial_dropped", npairs - p0, 0);
    send_frame(16, 32'h7E81, 32'h18E7);
    idle(12);
    chk("rehunt_pairs", npairs - p0, 1);
    chk("rehunt_left", last_l, 16'h7E81);
    chk("rehunt_right", last_r, 16'h18E7);

    // Fast BCLK (clk_in/4) with jitter, random words and random ready.
    #0.5;
    half_ns    = 40;
    jitter     = 1'b1;
    use_q      = 1'b1;
    rand_ready = 1'b1;
    p0 = npairs;
    f0 = nferr;
    for (int k = 0; k < NPAIRS; k++) begin
      n  = 16 + $urandom_range(0, 2);
      lv = $urandom;
      rv = $urandom;
      exp_q.push_back({model_word(n, lv), model_word(n, rv)});
      send_frame(n, lv, rv);
    end
    bclk = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk_in);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (4) @(negedge clk_in);
    chk("rand_queue_drained", exp_q.size(), 0);
    chk("rand_pair_count", npairs - p0, NPAIRS);
    chk("rand_overrun", overrun, 0);
    chk("rand_frame_err", nferr - f0, 0);
    use_q = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_i2s_rx_slave
`default_nettype wire
